// File: rtl/bus_rr_arbiter_pkg.sv
// Shared definitions for the four-master round-robin bus arbiter.
// Holds the master count, owner index width, IDLE/OWN state encoding,
// ENABLE_/DISABLE_ levels for active-low req_/grnt_, and the pick result type.
package bus_rr_arbiter_pkg;

  localparam int unsigned NUM_MASTERS = 4;
  localparam int unsigned OWNER_W     = 2;
  localparam int unsigned CNT_W       = 8;

  // Active-low bus handshake levels
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  typedef logic [NUM_MASTERS-1:0] req_vec_t;

  // Winner of a round-robin search
  typedef struct packed {
    logic               vld;
    logic [OWNER_W-1:0] idx;
  } pick_t;

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Arbitration bundle between the bus masters and the arbiter.
// Signals: m0_req_..m3_req_ (active-low requests), m0_grnt_..m3_grnt_
// (active-low grants), owner/owner_vld (current owner index), tmo (watchdog revoke pulse).
// Modports: master = requesting side, slave = arbiter side.
interface bus_rr_arbiter_if;
  import bus_rr_arbiter_pkg::*;

  logic               m0_req_;
  logic               m1_req_;
  logic               m2_req_;
  logic               m3_req_;
  logic               m0_grnt_;
  logic               m1_grnt_;
  logic               m2_grnt_;
  logic               m3_grnt_;
  logic [OWNER_W-1:0] owner;
  logic               owner_vld;
  logic               tmo;

  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_,
    input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, owner_vld, tmo
  );

  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner, owner_vld, tmo
  );

endinterface

// File: rtl/bus_rr_pick.sv
// Combinational round-robin search.
// Ports: req (active-high request vector), last (most recent owner),
// pick_c (first requester in order last+1, last+2, last+3, last; vld=0 if none).
module bus_rr_pick
  import bus_rr_arbiter_pkg::*;
(
  input  req_vec_t           req,
  input  logic [OWNER_W-1:0] last,
  output pick_t              pick_c
);

  logic [OWNER_W-1:0] idx;

  // Walk the order backwards so the earliest requester in search order wins.
  always_comb begin
    pick_c = '0;
    idx    = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = last + OWNER_W'(k);
      if (req[idx]) begin
        pick_c.vld = 1'b1;
        pick_c.idx = idx;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for the shared four-master bus, with a mandatory
// one-cycle turnaround between owners.
// Ports: clk, reset (async, active-high), bus (slave modport: req_/grnt_,
// owner, owner_vld, tmo). All bus outputs are registered.
// Optional hold-time watchdog enabled by defining BUS_ARB_WATCHDOG_EN;
// HOLD_LIMIT (2..255) is the max granted cycles while another master waits.
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_LIMIT = 16
) (
  input  logic           clk,
  input  logic           reset,
  bus_rr_arbiter_if.slave bus
);

  if (HOLD_LIMIT < 2 || HOLD_LIMIT > 255) begin : g_bad_limit
    $error("HOLD_LIMIT out of range 2..255");
  end

  req_vec_t           req;
  req_vec_t           others_c;
  pick_t              pick_c;
  state_t             state, state_nxt;
  logic [OWNER_W-1:0] last_q, last_nxt;
  logic [OWNER_W-1:0] owner_q, owner_nxt;
  req_vec_t           grnt_q, grnt_nxt;
  logic               vld_q, vld_nxt;
  logic               tmo_q, tmo_nxt;
  logic               release_c;
  logic               revoke_c;

  // Active-high view of the requests
  assign req = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};

  // Requests from everyone except the current owner
  always_comb begin
    others_c          = req;
    others_c[owner_q] = 1'b0;
  end

  assign release_c = (state == ST_OWN) && !req[owner_q];

  bus_rr_pick u_pick (
    .req    (req),
    .last   (last_q),
    .pick_c (pick_c)
  );

`ifdef BUS_ARB_WATCHDOG_EN
  logic [CNT_W-1:0] hold_q;

  // Normal release wins over a revoke on the same edge
  assign revoke_c = (state == ST_OWN) && !release_c && (others_c != '0) &&
                    (hold_q == CNT_W'(HOLD_LIMIT - 1));

  // Counts owned cycles during which some other master is waiting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
    end else if (state == ST_IDLE) begin
      hold_q <= '0;
    end else if ((others_c != '0) && (hold_q != CNT_W'(HOLD_LIMIT))) begin
      hold_q <= hold_q + CNT_W'(1);
    end
  end
`else
  assign revoke_c = 1'b0;
`endif

  // State, pointer and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      last_q  <= OWNER_W'(NUM_MASTERS - 1);
      owner_q <= '0;
      grnt_q  <= '1;
      vld_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      last_q  <= last_nxt;
      owner_q <= owner_nxt;
      grnt_q  <= grnt_nxt;
      vld_q   <= vld_nxt;
      tmo_q   <= tmo_nxt;
    end
  end

  // Next state, owner and priority pointer
  always_comb begin
    state_nxt = state;
    last_nxt  = last_q;
    owner_nxt = owner_q;
    case (state)
      ST_IDLE: begin
        if (pick_c.vld) begin
          state_nxt = ST_OWN;
          owner_nxt = pick_c.idx;
          last_nxt  = pick_c.idx;
        end
      end
      ST_OWN: begin
        if (release_c || revoke_c) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered bus outputs
  always_comb begin
    grnt_nxt = '1;
    vld_nxt  = (state_nxt == ST_OWN);
    tmo_nxt  = revoke_c;
    if (state_nxt == ST_OWN) begin
      grnt_nxt[owner_nxt] = ENABLE_;
    end
  end

  assign bus.m0_grnt_  = grnt_q[0];
  assign bus.m1_grnt_  = grnt_q[1];
  assign bus.m2_grnt_  = grnt_q[2];
  assign bus.m3_grnt_  = grnt_q[3];
  assign bus.owner     = owner_q;
  assign bus.owner_vld = vld_q;
  assign bus.tmo       = tmo_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios with literal expectations plus
// a per-cycle comparison against an owner/pointer level model.
module tb_bus_rr_arbiter;
  import bus_rr_arbiter_pkg::*;

  localparam int unsigned HL = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req   = 4'b0000;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  bus_rr_arbiter_if bus_if ();

  assign bus_if.m0_req_ = ~req[0];
  assign bus_if.m1_req_ = ~req[1];
  assign bus_if.m2_req_ = ~req[2];
  assign bus_if.m3_req_ = ~req[3];

  bus_rr_arbiter #(.HOLD_LIMIT(HL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  function automatic logic [3:0] dut_grnt();
    return {bus_if.m3_grnt_, bus_if.m2_grnt_, bus_if.m1_grnt_, bus_if.m0_grnt_};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner is -1 when the bus is free
  int m_own  = -1;
  int m_last = 3;
  int m_hold = 0;
  bit m_tmo  = 1'b0;
  bit m_found;
  int m_idx;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_own  = -1;
      m_last = 3;
      m_hold = 0;
      m_tmo  = 1'b0;
    end else begin
      m_tmo = 1'b0;
      if (m_own < 0) begin
        m_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          m_idx = (m_last + k) % 4;
          if (!m_found && req[m_idx]) begin
            m_found = 1'b1;
            m_own   = m_idx;
            m_last  = m_idx;
            m_hold  = 0;
          end
        end
      end else if (!req[m_own]) begin
        m_own = -1;
      end else if ((req & ~(4'b0001 << m_own)) != 4'b0000) begin
`ifdef BUS_ARB_WATCHDOG_EN
        if (m_hold + 1 >= int'(HL)) begin
          m_own = -1;
          m_tmo = 1'b1;
        end else begin
          m_hold++;
        end
`endif
      end
    end
  end

  function automatic logic [3:0] model_grnt();
    logic [3:0] g;
    g = 4'b1111;
    if (m_own >= 0) g[m_own] = 1'b0;
    return g;
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("cyc_grnt", int'(dut_grnt()), int'(model_grnt()));
    chk("cyc_vld", int'(bus_if.owner_vld), int'(m_own >= 0));
    chk("cyc_tmo", int'(bus_if.tmo), int'(m_tmo));
    if (m_own >= 0) chk("cyc_owner", int'(bus_if.owner), m_own);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int held, ngr, idle_cnt;
  bit prev_vld;
  int prev_own;
  logic [3:0] r;

  initial begin
    #1;
    reset = 1'b1;
    step();
    // Reset values
    chk("rst_grnt", int'(dut_grnt()), 15);
    chk("rst_owner", int'(bus_if.owner), 0);
    chk("rst_vld", int'(bus_if.owner_vld), 0);
    chk("rst_tmo", int'(bus_if.tmo), 0);
    reset = 1'b0;

    // Single request from master 1
    req = 4'b0010;
    step();
    chk("m1_grnt", int'(dut_grnt()), 4'b1101);
    chk("m1_owner", int'(bus_if.owner), 1);
    chk("m1_vld", int'(bus_if.owner_vld), 1);
    req = 4'b0000;
    step();
    chk("m1_drop", int'(dut_grnt()), 15);

    // All four requesting, each releasing after three granted cycles
    do_reset();
    held = 0; ngr = 0; idle_cnt = 0; prev_vld = 1'b0;
    for (int c = 0; c < 60 && ngr < 5; c++) begin
      r = 4'b1111;
      if (m_own >= 0 && held >= 3) r[m_own] = 1'b0;
      req = r;
      prev_own = m_own;
      step();
      if (m_own >= 0) held = (prev_own < 0) ? 1 : held + 1;
      if (bus_if.owner_vld && !prev_vld) begin
        chk("rr_order", int'(bus_if.owner), ngr % 4);
        if (ngr > 0) chk("rr_gap", idle_cnt, 1);
        ngr++;
        idle_cnt = 0;
      end else if (!bus_if.owner_vld) begin
        idle_cnt++;
      end
      prev_vld = bus_if.owner_vld;
    end
    chk("rr_count", ngr, 5);
    req = 4'b0000;
    step();

    // m0 releases while m2 waits
    do_reset();
    req = 4'b0101;
    step();
    chk("m0_first", int'(dut_grnt()), 4'b1110);
    step();
    req = 4'b0100;
    step();
    chk("turn_idle", int'(dut_grnt()), 15);
    chk("turn_vld", int'(bus_if.owner_vld), 0);
    step();
    chk("turn_m2", int'(dut_grnt()), 4'b1011);
    chk("turn_owner", int'(bus_if.owner), 2);
    req = 4'b0000;
    step();

    // m0 holds while m3 waits
    do_reset();
    req = 4'b0001;
    step();
    chk("wd_m0", int'(dut_grnt()), 4'b1110);
    req = 4'b1001;
`ifdef BUS_ARB_WATCHDOG_EN
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wd_hold", int'(dut_grnt()), 4'b1110);
      chk("wd_tmo_lo", int'(bus_if.tmo), 0);
    end
    step();
    chk("wd_tmo", int'(bus_if.tmo), 1);
    chk("wd_revoke", int'(dut_grnt()), 15);
    step();
    chk("wd_m3", int'(dut_grnt()), 4'b0111);
    chk("wd_owner3", int'(bus_if.owner), 3);
    chk("wd_tmo_end", int'(bus_if.tmo), 0);
`else
    for (int i = 0; i < 10; i++) begin
      step();
      chk("nowd_hold", int'(dut_grnt()), 4'b1110);
      chk("nowd_tmo", int'(bus_if.tmo), 0);
    end
`endif
    req = 4'b0000;
    step();
    step();

    // Asynchronous reset mid-grant
    req = 4'b0010;
    step();
    step();
    chk("ar_pre", int'(dut_grnt()), 4'b1101);
    req = 4'b0011;
    #2;
    reset = 1'b1;
    #1;
    chk("ar_grnt", int'(dut_grnt()), 15);
    chk("ar_vld", int'(bus_if.owner_vld), 0);
    step();
    reset = 1'b0;
    step();
    chk("ar_m0", int'(dut_grnt()), 4'b1110);
    chk("ar_owner", int'(bus_if.owner), 0);
    req = 4'b0000;
    step();

    // Quiet bus
    for (int i = 0; i < 20; i++) begin
      step();
      chk("quiet_vld", int'(bus_if.owner_vld), 0);
      chk("quiet_grnt", int'(dut_grnt()), 15);
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
